lagd_fifo_mc: RTL and testbench

//  Multi-channel FIFO for the flip manager: NUM_CH independent FIFO lanes behind a single clock/reset.

---
 rtl/lagd_fifo_mc_pkg.sv | 22 ++
 rtl/lagd_fifo_mc_lane.sv | 103 ++++++++++
 rtl/lagd_fifo_mc.sv | 72 +++++++
 tb/tb_lagd_fifo_mc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lagd_fifo_mc_pkg.sv
// lagd_fifo_mc_pkg: shared width helper and per-lane status bundle for the multi-channel FIFO.
// Revision 1.0
`default_nettype none

package lagd_fifo_mc_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic af;
        logic ae;
        logic ovf;
        logic udf;
    } lane_status_t;

endpackage

`default_nettype wire

// File: rtl/lagd_fifo_mc_lane.sv
// lagd_fifo_mc_lane: one FIFO lane with skip-push, fall-through bypass, thresholds and sticky errors.
// Revision 1.0
`default_nettype none

module lagd_fifo_mc_lane
    import lagd_fifo_mc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 8,
    parameter bit                    FALL_THROUGH = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    AF_THRESH    = DEPTH - 1,
    parameter int                    AE_THRESH    = 1,
    parameter int                    CNT_W        = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  skip_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      usage_o,
    output lane_status_t          status_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      usage;
    logic                  ovf;
    logic                  udf;

    logic is_empty;
    logic is_full;
    logic bypass;
    logic empty_vis;
    logic push_ok;
    logic pop_ok;
    logic wr_en;

    function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign is_empty  = (usage == '0);
    assign is_full   = (usage == FULL_CNT);
    // Bypass only for a real (non-skipped) push into an empty lane.
    assign bypass    = FALL_THROUGH && is_empty && push_i && !skip_i;
    assign empty_vis = is_empty && !bypass;
    assign pop_ok    = pop_i && !is_empty;
    assign push_ok   = push_i && !is_full && !(bypass && pop_i);
    assign wr_en     = push_ok && !skip_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            usage <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            usage <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push_ok) wptr <= ptr_incr(wptr);
            if (pop_ok)  rptr <= ptr_incr(rptr);
            if (push_ok && !pop_ok)      usage <= usage + CNT_W'(1);
            else if (pop_ok && !push_ok) usage <= usage - CNT_W'(1);
            if (push_i && is_full)       ovf <= 1'b1;
            if (pop_i && empty_vis)      udf <= 1'b1;
        end
    end

    // Storage is not cleared by flush; only reset restores the programmed content.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
        end else if (wr_en) begin
            mem[wptr] <= data_i;
        end
    end

    assign data_o         = bypass ? data_i : mem[rptr];
    assign usage_o        = usage;
    assign status_o.full  = is_full;
    assign status_o.empty = empty_vis;
    assign status_o.af    = (32'(usage) >= AF_THRESH);
    assign status_o.ae    = (32'(usage) <= AE_THRESH);
    assign status_o.ovf   = ovf;
    assign status_o.udf   = udf;

endmodule

`default_nettype wire

// File: rtl/lagd_fifo_mc.sv
// lagd_fifo_mc: NUM_CH independent FIFO lanes sharing one clock/reset, with packed lane ports.
// Revision 1.0
`default_nettype none

module lagd_fifo_mc
    import lagd_fifo_mc_pkg::*;
#(
    parameter int                    NUM_CH       = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 8,
    parameter bit                    FALL_THROUGH = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    AF_THRESH    = DEPTH - 1,
    parameter int                    AE_THRESH    = 1,
    parameter int                    CNT_W        = cnt_width(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            flush_i,
    input  logic [NUM_CH-1:0]            push_i,
    input  logic [NUM_CH-1:0]            skip_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]            pop_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]            full_o,
    output logic [NUM_CH-1:0]            empty_o,
    output logic [NUM_CH-1:0]            almost_full_o,
    output logic [NUM_CH-1:0]            almost_empty_o,
    output logic [NUM_CH*CNT_W-1:0]      usage_o,
    output logic [NUM_CH-1:0]            ovf_o,
    output logic [NUM_CH-1:0]            udf_o
);

    if (DEPTH < 1 || DEPTH > 65536) begin : g_depth_check
        $fatal(1, "lagd_fifo_mc: DEPTH must be in 1..65536");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        lane_status_t status;

        lagd_fifo_mc_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .DEPTH        (DEPTH),
            .FALL_THROUGH (FALL_THROUGH),
            .RESET_VALUE  (RESET_VALUE),
            .AF_THRESH    (AF_THRESH),
            .AE_THRESH    (AE_THRESH),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .flush_i  (flush_i[c]),
            .push_i   (push_i[c]),
            .skip_i   (skip_i[c]),
            .data_i   (data_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i    (pop_i[c]),
            .data_o   (data_o[c*DATA_WIDTH +: DATA_WIDTH]),
            .usage_o  (usage_o[c*CNT_W +: CNT_W]),
            .status_o (status)
        );

        assign full_o[c]         = status.full;
        assign empty_o[c]        = status.empty;
        assign almost_full_o[c]  = status.af;
        assign almost_empty_o[c] = status.ae;
        assign ovf_o[c]          = status.ovf;
        assign udf_o[c]          = status.udf;
    end

endmodule

`default_nettype wire

// File: tb/tb_lagd_fifo_mc.sv
// tb_lagd_fifo_mc: directed self-checking bench, one standard and one fall-through instance.
// Revision 1.0
`default_nettype none

module tb_lagd_fifo_mc;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int CW  = 2;

    logic clk;
    logic rst_n;

    logic [NCH-1:0]    flush, push, skip, pop;
    logic [NCH*DW-1:0] din;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    full, empty, af, ae, ovf, udf;
    logic [NCH*CW-1:0] usage;

    logic [NCH-1:0]    ft_flush, ft_push, ft_skip, ft_pop;
    logic [NCH*DW-1:0] ft_din;
    logic [NCH*DW-1:0] ft_dout;
    logic [NCH-1:0]    ft_full, ft_empty, ft_af, ft_ae, ft_ovf, ft_udf;
    logic [NCH*CW-1:0] ft_usage;

    int n_vec;
    int n_err;

    lagd_fifo_mc #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(3), .FALL_THROUGH(1'b0),
        .RESET_VALUE(8'h7F), .AF_THRESH(2), .AE_THRESH(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .skip_i(skip),
        .data_i(din), .pop_i(pop), .data_o(dout), .full_o(full), .empty_o(empty),
        .almost_full_o(af), .almost_empty_o(ae), .usage_o(usage), .ovf_o(ovf), .udf_o(udf)
    );

    lagd_fifo_mc #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(3), .FALL_THROUGH(1'b1),
        .RESET_VALUE(8'h7F), .AF_THRESH(2), .AE_THRESH(1)
    ) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(ft_flush), .push_i(ft_push), .skip_i(ft_skip),
        .data_i(ft_din), .pop_i(ft_pop), .data_o(ft_dout), .full_o(ft_full), .empty_o(ft_empty),
        .almost_full_o(ft_af), .almost_empty_o(ft_ae), .usage_o(ft_usage), .ovf_o(ft_ovf),
        .udf_o(ft_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = '0; push = '0; skip = '0; pop = '0; din = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        ft_flush = '0; ft_push = '0; ft_skip = '0; ft_pop = '0; ft_din = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data",  32'(dout),  32'h7F7F);
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_usage", 32'(usage), 32'h0);
        chk("rst_ae",    32'(ae),    32'h3);
        chk("rst_af",    32'(af),    32'h0);
        chk("rst_full",  32'(full),  32'h0);
        chk("rst_err",   32'({ovf, udf}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Lane0: push 11, skipped push, push 33
        push = 2'b01; din = 16'h0011; tick();
        skip = 2'b01; din = 16'h00EE; tick();
        skip = 2'b00; din = 16'h0033; tick();
        idle();
        chk("fill_usage", 32'(usage[1:0]), 32'd3);
        chk("fill_full",  32'(full),       32'h1);
        chk("fill_af",    32'(af),         32'h1);
        chk("fill_head",  32'(dout[7:0]),  32'h11);
        pop = 2'b01; tick();
        chk("pop1_usage", 32'(usage[1:0]), 32'd2);
        chk("pop1_head",  32'(dout[7:0]),  32'h7F);
        tick();
        chk("pop2_usage", 32'(usage[1:0]), 32'd1);
        chk("pop2_head",  32'(dout[7:0]),  32'h33);
        tick();
        idle();
        chk("pop3_usage", 32'(usage[1:0]), 32'd0);
        chk("pop3_empty", 32'(empty),      32'h3);
        chk("stale_head", 32'(dout[7:0]),  32'h11);

        // Overflow on a full lane0
        push = 2'b01;
        din = 16'h00A1; tick();
        din = 16'h00A2; tick();
        din = 16'h00A3; tick();
        din = 16'h00AA; tick();
        idle();
        chk("ovf_set",   32'(ovf),          32'h1);
        chk("ovf_usage", 32'(usage[1:0]),   32'd3);
        chk("ovf_head",  32'(dout[7:0]),    32'hA1);
        chk("ovf_lane1", 32'(usage[3:2]),   32'd0);
        tick();
        chk("ovf_stick", 32'(ovf),          32'h1);
        pop = 2'b01; tick(); idle();
        chk("ovf_pop",   32'(dout[7:0]),    32'hA2);
        flush = 2'b01; push = 2'b01; din = 16'h00BB; tick(); idle();
        chk("flush_ovf",   32'(ovf),        32'h0);
        chk("flush_usage", 32'(usage[1:0]), 32'd0);
        chk("flush_empty", 32'(empty[0]),   32'h1);
        chk("flush_mem",   32'(dout[7:0]),  32'hA1);

        // Lane1 wrap with steady usage of one
        push = 2'b10; din = 16'hB000; tick();
        for (int i = 1; i <= 5; i++) begin
            push = 2'b10; pop = 2'b10; din = {8'(8'hB0 + i), 8'h00};
            #1;
            chk("wrap_head", 32'(dout[15:8]), 32'(8'hB0 + i - 1));
            tick();
            chk("wrap_usage", 32'(usage[3:2]), 32'd1);
        end
        idle();
        chk("wrap_last", 32'(dout[15:8]), 32'hB5);
        pop = 2'b10; tick(); idle();
        chk("wrap_drain", 32'(usage[3:2]), 32'd0);

        // Underflow on empty lane1
        pop = 2'b10; tick(); idle();
        chk("udf_set", 32'(udf), 32'h2);
        tick();
        chk("udf_stick", 32'(udf), 32'h2);

        // Fall-through bypass on lane0 of the second instance
        ft_push = 2'b01; ft_pop = 2'b01; ft_din = 16'h005C;
        #1;
        chk("ft_data",  32'(ft_dout[7:0]), 32'h5C);
        chk("ft_empty", 32'(ft_empty[0]),  32'h0);
        tick();
        ft_push = '0; ft_pop = '0;
        #1;
        chk("ft_usage", 32'(ft_usage[1:0]), 32'd0);
        chk("ft_udf",   32'(ft_udf),        32'h0);
        ft_push = 2'b01; ft_pop = 2'b01; ft_skip = 2'b01;
        #1;
        chk("fts_empty", 32'(ft_empty[0]), 32'h1);
        tick();
        ft_push = '0; ft_pop = '0; ft_skip = '0;
        #1;
        chk("fts_udf",   32'(ft_udf),         32'h1);
        chk("fts_usage", 32'(ft_usage[1:0]),  32'd1);
        chk("fts_head",  32'(ft_dout[7:0]),   32'h7F);

        // Asynchronous reset mid-stream
        push = 2'b11; din = 16'h6655; tick();
        rst_n = 1'b0;
        #1;
        chk("arst_usage", 32'(usage), 32'h0);
        chk("arst_err",   32'({ovf, udf}), 32'h0);
        chk("arst_data",  32'(dout),  32'h7F7F);
        chk("arst_empty", 32'(empty), 32'h3);
        chk("arst_ft",    32'({ft_usage, ft_udf}), 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_usage", 32'(usage), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
